// File: rtl/video_store_buffer_if.sv
// VRAM write port between the store buffer and the framebuffer.
// The buffer presents the head entry; the VRAM side accepts it with ready.
interface video_store_buffer_if #(
  parameter int ADDR_W = 15
);
  logic              vram_valid;
  logic              vram_ready;
  logic [ADDR_W-1:0] vram_waddr;
  logic [31:0]       vram_wdata;

  modport master (
    output vram_valid,
    output vram_waddr,
    output vram_wdata,
    input  vram_ready
  );

  modport slave (
    input  vram_valid,
    input  vram_waddr,
    input  vram_wdata,
    output vram_ready
  );
endinterface

// File: rtl/video_store_buffer.sv
// Buffers core VRAM stores in a show-ahead FIFO and drains them to VRAM.
// Define VIDEO_COALESCE_EN to merge repeat writes to the newest entry.
module video_store_buffer #(
  parameter int          DEPTH      = 8,
  parameter logic [31:0] VRAM_BASE  = 32'h0000_8000,
  parameter int          VRAM_WORDS = 19200,
  parameter int          ADDR_W     = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        video_we,
  input  logic [31:0] video_addr,
  input  logic [31:0] video_data,
  input  logic        flush_req,
  video_store_buffer_if.master vram,
  output logic [$clog2(DEPTH):0] fifo_level,
  output logic        overflow,
  output logic [15:0] drop_count,
  output logic [15:0] oor_count,
  output logic        flush_done
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam logic [29:0] WORDS30 = 30'(VRAM_WORDS);
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] DRAIN = 1'b1;

  logic [ADDR_W-1:0] mem_a [DEPTH];
  logic [31:0]       mem_d [DEPTH];
  logic [PW-1:0]     rd_ptr;
  logic [PW-1:0]     wr_ptr;
  logic [LW-1:0]     level;
  logic [0:0]        state;

  logic [31:0]       off;
  logic              in_range;
  logic [ADDR_W-1:0] idx;
  logic              wr_ok;
  logic              pop;
  logic              full;
  logic              coalesce;
  logic              push;
  logic              drop;
  logic              oor;
  logic              empty_now;

  assign off      = video_addr - VRAM_BASE;
  assign in_range = (video_addr >= VRAM_BASE)
                 && (off[1:0] == 2'b00)
                 && (off[31:2] < WORDS30);
  assign idx      = off[ADDR_W+1:2];
  assign wr_ok    = video_we && in_range;
  assign oor      = video_we && !in_range;

  assign vram.vram_valid = (level != '0);
  assign pop  = vram.vram_valid && vram.vram_ready;
  assign full = (level == FULL_LVL);

`ifdef VIDEO_COALESCE_EN
  logic [PW-1:0] tail_ptr;
  assign tail_ptr = wr_ptr - PW'(1);
  // The tail is the newest entry; it is only unsafe when it is also the head being popped.
  assign coalesce = wr_ok
                 && (level != '0)
                 && (mem_a[tail_ptr] == idx)
                 && !(pop && level == LW'(1));
`else
  assign coalesce = 1'b0;
`endif

  assign push = wr_ok && !coalesce && (!full || pop);
  assign drop = wr_ok && !coalesce && full && !pop;
  assign empty_now = (level == '0) && !push;

  assign vram.vram_waddr = vram.vram_valid ? mem_a[rd_ptr] : '0;
  assign vram.vram_wdata = vram.vram_valid ? mem_d[rd_ptr] : '0;
  assign fifo_level = level;

  always_ff @(posedge clk) begin
    if (push) begin
      mem_a[wr_ptr] <= idx;
      mem_d[wr_ptr] <= video_data;
    end
`ifdef VIDEO_COALESCE_EN
    if (coalesce) begin
      mem_d[tail_ptr] <= video_data;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      unique case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      overflow   <= 1'b0;
      drop_count <= '0;
      oor_count  <= '0;
    end else begin
      if (drop) overflow <= 1'b1;
      if (drop && drop_count != 16'hFFFF)
        drop_count <= drop_count + 16'd1;
      if (oor && oor_count != 16'hFFFF)
        oor_count <= oor_count + 16'd1;
    end
  end

  // A flush of an already empty buffer completes on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      flush_done <= 1'b0;
    end else begin
      flush_done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (flush_req) begin
            if (empty_now) flush_done <= 1'b1;
            else           state      <= DRAIN;
          end
        end
        DRAIN: begin
          if (empty_now) begin
            flush_done <= 1'b1;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/video_store_buffer.md
Name: video_store_buffer

Overview:
- Sits directly downstream of the core's MEM-stage video tap and consumes the core's `video_we`, `video_addr` and `video_data`.
- Translates byte addresses into VRAM word indices and buffers the writes in a show-ahead FIFO.
- Drains the FIFO into the VRAM/framebuffer write port over a valid/ready handshake.
- The core never stalls on video traffic, so this block absorbs bursts and reports any losses. It also supports an end-of-program drain handshake.

Parameters:
- DEPTH, 8: FIFO entries; power of two, at least 2.
- VRAM_BASE, 32'h00008000: byte address of VRAM word 0.
- VRAM_WORDS, 19200: number of valid VRAM words (160x120).
- ADDR_W, 15: width of the VRAM word index; 2^ADDR_W >= VRAM_WORDS.

Ports:
- clk  in  1  clock
- rst  in  1  reset. Synchronous, active-high; clock clk.
- video_we  in  1  store-to-VRAM strobe from the core, one write per cycle max
- video_addr  in  32  byte address of the store
- video_data  in  32  store data
- flush_req  in  1  one-cycle pulse: drain the FIFO
- vram_valid  out  1  head entry is valid
- vram_ready  in  1  VRAM accepts the head this cycle
- vram_waddr  out  ADDR_W  word index of the head entry
- vram_wdata  out  32  data of the head entry
- fifo_level  out  $clog2(DEPTH)+1  current occupancy
- overflow  out  1  sticky; set when any write was dropped because the FIFO was full
- drop_count  out  16  count of full-FIFO drops, saturating at 16'hFFFF
- oor_count  out  16  count of out-of-range or misaligned writes, saturating
- flush_done  out  1  one-cycle pulse when a requested drain completes

Behaviour:
- **Reset:**
  - All outputs are 0: vram_valid, vram_waddr, vram_wdata, fifo_level, overflow, drop_count, oor_count, flush_done.
  - Read/write pointers are cleared and the FSM goes to IDLE.
  - Reset mid-operation discards every buffered entry with no VRAM write; vram_valid drops in the cycle after the reset edge.
- **Address check:**
  - off = video_addr - VRAM_BASE, computed in 32-bit unsigned arithmetic.
  - A write is in range iff video_addr >= VRAM_BASE, off[1:0] == 0 and off[31:2] < VRAM_WORDS.
  - The index is off[ADDR_W+1:2].
  - A write that fails the check is discarded and oor_count increments, saturating.
- **Push:** an in-range write is accepted if fifo_level < DEPTH, or if a pop occurs in the same cycle (full with simultaneous pop is accepted).
  - Otherwise the write is dropped, overflow is set and drop_count increments, saturating.
- **Pop:**
  - Occurs when vram_valid && vram_ready.
  - vram_valid = (fifo_level != 0).
  - vram_waddr and vram_wdata show the head entry combinationally from storage and stay stable while vram_valid && !vram_ready.
- **Latency:** a write accepted at edge N is presented at the VRAM port in cycle N+1 if the FIFO was empty.
- **Ordering:** entries drain in strict FIFO order.
- **Level:** fifo_level changes by +1 on push only, -1 on pop only, and is unchanged on simultaneous push and pop. Pointers wrap modulo DEPTH.
- **FSM IDLE/DRAIN:**
  - IDLE -> DRAIN on flush_req.
  - DRAIN -> IDLE with flush_done = 1 for one cycle once the FIFO is empty and no push occurs that cycle.
  - flush_req with an empty FIFO gives flush_done on the next edge.
  - Pushes are still accepted in DRAIN and extend the drain.
  - flush_req while already in DRAIN is ignored.

Optional Feature:
- Macro: VIDEO_COALESCE_EN.
- **Defined:** an in-range write whose index equals the most recently pushed entry overwrites that entry's data with no push, provided that entry is still in the FIFO and is not being popped this cycle.
  - fifo_level is unchanged; no drop and no overflow.
- **Undefined:** every accepted write occupies its own entry.

Test Plan:
- Reset, then video_we with addr 0x8000 data 0xAA, then addr 0x8004 data 0xBB, vram_ready = 1 -> VRAM sees index 0/0xAA in cycle N+1 and index 1/0xBB in the next cycle; fifo_level returns to 0.
- vram_ready = 0, 9 writes to 0x8000+4k (DEPTH = 8) -> fifo_level = 8, 9th dropped, overflow = 1, drop_count = 1. Then ready = 1 -> indices 0..7 drain in order.
- FIFO full, vram_ready = 1 with a write in the same cycle -> write accepted, fifo_level stays 8, drop_count unchanged.
- Writes to 0x7FFC, 0x8002 and 0x8000+4*19200 -> none pushed, oor_count = 3; 0x8000+4*19199 -> pushed as index 19199.
- 3 entries buffered, ready = 0, flush_req pulse -> flush_done stays low; ready = 1 -> flush_done pulses exactly one cycle after the last pop. flush_req while empty -> flush_done on the next edge.
- VIDEO_COALESCE_EN, ready = 0, writes 0x8010/0x1 then 0x8010/0x2 -> fifo_level = 1; drain yields index 4 with data 0x2. Without the macro: fifo_level = 2, data 0x1 then 0x2.
